// File: rtl/temp_ascii_fmt.sv
// Formats one signed DS18B20 temperature word into an ASCII line ("+025.0625\r\n") for the UART.
// Optional build macro TEMP_FMT_CHECKSUM_EN appends "*HH" (XOR of sign..last fraction digit).

module temp_ascii_fmt_dd (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module temp_ascii_fmt #(
  parameter bit LINE_CR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  input  logic        temp_valid,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

`ifdef TEMP_FMT_CHECKSUM_EN
  localparam int CHK_BYTES = 3;
`else
  localparam int CHK_BYTES = 0;
`endif
  localparam int         LINE_LEN = 9 + CHK_BYTES + (LINE_CR ? 2 : 1);
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);
  localparam logic [3:0] TERM_IDX = 4'(9 + CHK_BYTES);
  localparam int         NDIG     = 3;

  logic [1:0]  state;
  logic        neg;
  logic [3:0]  fn;
  logic [9:0]  bin;
  logic [11:0] bcd;
  logic [3:0]  cnt;
  logic [3:0]  idx;
`ifdef TEMP_FMT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Capture-side magnitude and saturation; 0x8000 negates to 32768 in 16 bits.
  logic [15:0] mag;
  logic [11:0] ip_full;
  logic        sat;
  logic [9:0]  ip_sat;
  logic [3:0]  fn_sat;

  assign mag     = temp_raw[15] ? 16'(16'd0 - temp_raw) : temp_raw;
  assign ip_full = mag[15:4];
  assign sat     = ip_full > 12'd999;
  assign ip_sat  = sat ? 10'd999 : ip_full[9:0];
  assign fn_sat  = sat ? 4'd15 : mag[3:0];

  // One shift-and-add-3 step: adjust each BCD digit, then shift the next binary bit in.
  logic [11:0] bcd_adj;

  for (genvar g = 0; g < NDIG; g++) begin : g_dd
    temp_ascii_fmt_dd u_dd (
      .din  (bcd[g*4 +: 4]),
      .dout (bcd_adj[g*4 +: 4])
    );
  end

  function automatic logic [15:0] frac_bcd(input logic [3:0] f);
    case (f)
      4'd0:    frac_bcd = 16'h0000;
      4'd1:    frac_bcd = 16'h0625;
      4'd2:    frac_bcd = 16'h1250;
      4'd3:    frac_bcd = 16'h1875;
      4'd4:    frac_bcd = 16'h2500;
      4'd5:    frac_bcd = 16'h3125;
      4'd6:    frac_bcd = 16'h3750;
      4'd7:    frac_bcd = 16'h4375;
      4'd8:    frac_bcd = 16'h5000;
      4'd9:    frac_bcd = 16'h5625;
      4'd10:   frac_bcd = 16'h6250;
      4'd11:   frac_bcd = 16'h6875;
      4'd12:   frac_bcd = 16'h7500;
      4'd13:   frac_bcd = 16'h8125;
      4'd14:   frac_bcd = 16'h8750;
      default: frac_bcd = 16'h9375;
    endcase
  endfunction

`ifdef TEMP_FMT_CHECKSUM_EN
  function automatic logic [7:0] hex_char(input logic [3:0] v);
    hex_char = (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction
`endif

  logic [15:0] fbcd;
  logic [3:0]  sel_idx;
  logic [7:0]  byte_nx;

  assign fbcd    = frac_bcd(fn);
  assign sel_idx = (state == S_SEND) ? 4'(idx + 4'd1) : 4'd0;

  always_comb begin
    byte_nx = 8'h0A;
    case (sel_idx)
      4'd0:    byte_nx = neg ? 8'h2D : 8'h2B;
      4'd1:    byte_nx = {4'h3, bcd[11:8]};
      4'd2:    byte_nx = {4'h3, bcd[7:4]};
      4'd3:    byte_nx = {4'h3, bcd[3:0]};
      4'd4:    byte_nx = 8'h2E;
      4'd5:    byte_nx = {4'h3, fbcd[15:12]};
      4'd6:    byte_nx = {4'h3, fbcd[11:8]};
      4'd7:    byte_nx = {4'h3, fbcd[7:4]};
      4'd8:    byte_nx = {4'h3, fbcd[3:0]};
`ifdef TEMP_FMT_CHECKSUM_EN
      4'd9:    byte_nx = 8'h2A;
      4'd10:   byte_nx = hex_char(csum[7:4]);
      4'd11:   byte_nx = hex_char(csum[3:0]);
`endif
      TERM_IDX: byte_nx = LINE_CR ? 8'h0D : 8'h0A;
      default: byte_nx = 8'h0A;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      neg      <= 1'b0;
      fn       <= 4'd0;
      bin      <= 10'd0;
      bcd      <= 12'd0;
      cnt      <= 4'd0;
      idx      <= 4'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
`ifdef TEMP_FMT_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx_valid <= 1'b0;
          if (temp_valid) begin
            neg   <= temp_raw[15];
            fn    <= fn_sat;
            bin   <= ip_sat;
            bcd   <= 12'd0;
            cnt   <= 4'd0;
            state <= S_CONV;
`ifdef TEMP_FMT_CHECKSUM_EN
            csum  <= 8'h00;
`endif
          end
        end
        S_CONV: begin
          if (cnt != 4'd10) begin
            bcd <= {bcd_adj[10:0], bin[9]};
            bin <= {bin[8:0], 1'b0};
            cnt <= cnt + 4'd1;
          end else begin
            // Digits are settled: present the sign byte one edge after the last iteration.
            idx      <= 4'd0;
            tx_data  <= byte_nx;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
`ifdef TEMP_FMT_CHECKSUM_EN
            if (idx <= 4'd8) csum <= csum ^ tx_data;
`endif
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= byte_nx;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_ascii_fmt.sv
// Directed bench for temp_ascii_fmt: latency, line contents, backpressure, mid-line reset.
module tb_temp_ascii_fmt;
  localparam bit LCR = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] temp_raw = 16'h0000;
  logic        temp_valid = 1'b0;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  temp_ascii_fmt #(.LINE_CR(LCR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_raw   (temp_raw),
    .temp_valid (temp_valid),
    .busy       (busy),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    string       body;
  } vec_t;

  vec_t       vecs[10];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  bit         timed_out;
  bit         stable_bad;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] v);
    hexc = (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  task automatic build_exp(input string body);
    logic [7:0] x;
    x = 8'h00;
    expq.delete();
    for (int i = 0; i < body.len(); i++) begin
      expq.push_back(body.getc(i));
      x = x ^ body.getc(i);
    end
`ifdef TEMP_FMT_CHECKSUM_EN
    expq.push_back(8'h2A);
    expq.push_back(hexc(x[7:4]));
    expq.push_back(hexc(x[3:0]));
`endif
    if (LCR) expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  // Reports the index of the first differing byte, -1 when the line matches.
  task automatic compare_line(input string body);
    int bad;
    build_exp(body);
    bad = -1;
    for (int i = 0; i < 16; i++) begin
      if (i >= rxq.size() && i >= expq.size()) break;
      if (i >= rxq.size() || i >= expq.size() || rxq[i] !== expq[i]) begin
        bad = i;
        break;
      end
    end
    chk({"line ", body, " first bad byte"}, bad, -1);
  endtask

  // Returns at the falling edge after capture edge E0.
  task automatic send_sample(input logic [15:0] raw);
    @(negedge clk);
    temp_raw   = raw;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic collect(input bit stall, input bit pulse);
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         hs;
    rxq.delete();
    timed_out  = 1'b1;
    stable_bad = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (prev_stall && !(tx_valid === 1'b1 && tx_data === prev_data)) stable_bad = 1'b1;
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse && rxq.size() == 3) begin
        temp_raw   = 16'h07D0;
        temp_valid = 1'b1;
      end else begin
        temp_valid = 1'b0;
      end
      hs = tx_valid && tx_ready;
      if (hs) rxq.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    temp_valid = 1'b0;
    tx_ready   = 1'b1;
    chk("line finished within budget", timed_out, 0);
  endtask

  task automatic idle_check(input string name);
    int seen;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || busy) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int first_v;
    int drop_e;

    vecs[0] = '{16'h0191, "+025.0625"};
    vecs[1] = '{16'hFFF8, "-000.5000"};
    vecs[2] = '{16'hFC90, "-055.0000"};
    vecs[3] = '{16'h07D0, "+125.0000"};
    vecs[4] = '{16'h7FFF, "+999.9375"};
    vecs[5] = '{16'h8000, "-999.9375"};
    vecs[6] = '{16'h0000, "+000.0000"};
    vecs[7] = '{16'hFFFF, "-000.0625"};
    vecs[8] = '{16'h3E7F, "+999.9375"};
    vecs[9] = '{16'h3E80, "+999.9375"};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: busy after E0, tx_valid after E11, busy drops on the last handshake edge.
    build_exp("+025.0625");
    tx_ready = 1'b1;
    send_sample(16'h0191);
    chk("busy after E0", busy, 1);
    rxq.delete();
    first_v = -1;
    drop_e  = -1;
    for (int e = 1; e <= 100; e++) begin
      if (tx_valid) rxq.push_back(tx_data);
      @(negedge clk);
      if (tx_valid && first_v < 0) first_v = e;
      if (!busy) begin
        drop_e = e;
        break;
      end
    end
    chk("first tx_valid edge", first_v, 11);
    chk("busy drop edge", drop_e, 11 + expq.size());
    chk("tx_valid low at end", tx_valid, 0);
    compare_line("+025.0625");

    foreach (vecs[i]) begin
      send_sample(vecs[i].raw);
      collect(1'b0, 1'b0);
      compare_line(vecs[i].body);
      chk("tx_valid low after line", tx_valid, 0);
    end

    // Random backpressure with a stray temp_valid during SEND.
    send_sample(16'h0191);
    collect(1'b1, 1'b1);
    compare_line("+025.0625");
    chk("data stable while stalled", stable_bad, 0);
    idle_check("no second line after ignored pulse");

    // Reset while byte 4 ('.') is on the bus.
    send_sample(16'h0191);
    repeat (15) @(negedge clk);
    chk("byte 4 before reset", tx_data, 8'h2E);
    rst_n = 1'b0;
    #1;
    chk("async reset tx_valid", tx_valid, 0);
    chk("async reset busy", busy, 0);
    chk("async reset tx_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_sample(16'hFC90);
    collect(1'b0, 1'b0);
    compare_line("-055.0000");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
